// File: rtl/mmio_dram.sv
// Data RAM with a memory-mapped I/O window: STATUS, synchronised inputs, output ports.
// Define MMIO_DRAM_BCD_LUT_EN to preload the heart-rate BCD table on RESET.
module mmio_dram #(
    parameter int DW    = 8,
    parameter int AW    = 8,
    parameter int N_IN  = 3,
    parameter int N_OUT = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [AW-1:0]       ADDR,
    input  logic [DW-1:0]       DATA,
    input  logic                MW,
    output logic [DW-1:0]       Q,
    input  logic [N_IN*DW-1:0]  IN_BUS,
    output logic [N_OUT*DW-1:0] OUT_BUS,
    output logic                IRQ
);
    localparam int DEPTH   = 2 ** AW;
    localparam int IO_BASE = DEPTH - (N_IN + N_OUT + 1);
    localparam int IW      = $clog2(IO_BASE);

    localparam logic [AW-1:0] STAT_A = AW'(IO_BASE);
    localparam logic [AW-1:0] IN_A   = AW'(IO_BASE + 1);
    localparam logic [AW-1:0] OUT_A  = AW'(IO_BASE + N_IN + 1);

    logic [DW-1:0]       mem_q [IO_BASE];
    logic [DW-1:0]       q_q, q_d;
    logic [N_IN*DW-1:0]  s1_q, s2_q, s3_q;
    logic [N_IN-1:0]     stat_q, stat_d;
    logic [N_IN-1:0]     chg, clr;
    logic [N_OUT*DW-1:0] out_q, out_d;
    logic [DW-1:0]       in_rd, out_rd;
    logic                is_ram, is_stat, is_in;

    assign is_ram  = ADDR < STAT_A;
    assign is_stat = ADDR == STAT_A;
    assign is_in   = !is_ram && !is_stat && (ADDR < OUT_A);

    always_comb begin
        in_rd  = '0;
        out_rd = '0;
        out_d  = out_q;
        for (int k = 0; k < N_IN; k++) begin
            if (ADDR == IN_A + AW'(k))
                in_rd = s2_q[k*DW +: DW];
        end
        for (int k = 0; k < N_OUT; k++) begin
            if (ADDR == OUT_A + AW'(k)) begin
                out_rd = out_q[k*DW +: DW];
                if (MW)
                    out_d[k*DW +: DW] = DATA;
            end
        end
    end

    always_comb begin
        chg = '0;
        for (int k = 0; k < N_IN; k++)
            chg[k] = s2_q[k*DW +: DW] != s3_q[k*DW +: DW];
    end

    // A change detected in the same cycle as a clear keeps the flag set.
    assign clr    = (MW && is_stat) ? DATA[N_IN-1:0] : '0;
    assign stat_d = (stat_q & ~clr) | chg;

    always_comb begin
        q_d = '0;
        unique case (1'b1)
            is_ram:  q_d = mem_q[ADDR[IW-1:0]];
            is_stat: q_d[N_IN-1:0] = stat_q;
            is_in:   q_d = in_rd;
            default: q_d = out_rd;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            q_q    <= '0;
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
            stat_q <= '0;
            out_q  <= '0;
        end else begin
            q_q    <= q_d;
            s1_q   <= IN_BUS;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            stat_q <= stat_d;
            out_q  <= out_d;
        end
    end

`ifdef MMIO_DRAM_BCD_LUT_EN
    localparam int HR_N = 30;
    localparam int HR_TAB [HR_N] = '{
        0, 8, 17, 26, 35, 44, 53, 62, 71, 80,
        89, 98, 107, 116, 125, 133, 142, 151, 160, 169,
        178, 187, 196, 205, 214, 223, 232, 241, 250, 259
    };

    function automatic logic [15:0] bcd16(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10),
                4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    if (DW != 8 || IO_BASE < 2 * HR_N) begin : g_bad_cfg
        $error("mmio_dram: BCD table needs DW=8 and IO_BASE>=60");
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < HR_N; i++) begin
                mem_q[IW'(2*i)]   <= DW'(bcd16(HR_TAB[i]));
                mem_q[IW'(2*i+1)] <= DW'(bcd16(HR_TAB[i]) >> 8);
            end
        end else if (MW && is_ram) begin
            mem_q[ADDR[IW-1:0]] <= DATA;
        end
    end
`else
    always_ff @(posedge CLK) begin
        if (!RESET && MW && is_ram)
            mem_q[ADDR[IW-1:0]] <= DATA;
    end
`endif

    assign Q       = q_q;
    assign OUT_BUS = out_q;
    assign IRQ     = |stat_q;

endmodule

// File: tb/tb_mmio_dram.sv
// Bench for mmio_dram: address-level reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_mmio_dram;
    logic        CLK;
    logic        RESET;
    logic [7:0]  ADDR;
    logic [7:0]  DATA;
    logic        MW;
    logic [7:0]  Q;
    logic [23:0] IN_BUS;
    logic [31:0] OUT_BUS;
    logic        IRQ;

    int n_chk  = 0;
    int n_pass = 0;
    bit go     = 0;

    mmio_dram #(.DW(8), .AW(8), .N_IN(3), .N_OUT(4)) dut (
        .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .DATA(DATA), .MW(MW),
        .Q(Q), .IN_BUS(IN_BUS), .OUT_BUS(OUT_BUS), .IRQ(IRQ)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference model: memory map by address, pins seen through a 3-deep sample history
    logic [7:0]  m_mem [256];
    bit          m_known [256];
    logic [7:0]  m_out [4];
    logic [2:0]  m_stat;
    logic [23:0] m_pins [$];
    logic [7:0]  m_q;
    bit          m_qk;
    int          m_a;
    logic [23:0] m_seen, m_prev;
    logic [2:0]  m_chg, m_clr;
`ifdef MMIO_DRAM_BCD_LUT_EN
    int hr [30] = '{0, 8, 17, 26, 35, 44, 53, 62, 71, 80,
                    89, 98, 107, 116, 125, 133, 142, 151, 160, 169,
                    178, 187, 196, 205, 214, 223, 232, 241, 250, 259};
`endif

    always @(posedge CLK) begin
        if (RESET) begin
            m_q = 8'h00;
            m_qk = 1'b1;
            m_stat = 3'b000;
            for (int k = 0; k < 4; k++) m_out[k] = 8'h00;
            m_pins = '{24'h0, 24'h0, 24'h0};
`ifdef MMIO_DRAM_BCD_LUT_EN
            for (int i = 0; i < 30; i++) begin
                m_mem[2*i]   = 8'((hr[i] / 10 % 10) * 16 + hr[i] % 10);
                m_mem[2*i+1] = 8'((hr[i] / 1000 % 10) * 16 + hr[i] / 100 % 10);
                m_known[2*i] = 1'b1;
                m_known[2*i+1] = 1'b1;
            end
`endif
        end else begin
            m_a = int'(ADDR);
            m_seen = m_pins[1];
            m_prev = m_pins[2];
            m_qk = 1'b1;
            if (m_a < 248) begin
                m_q = m_mem[m_a];
                m_qk = m_known[m_a];
            end else if (m_a == 248) m_q = {5'b0, m_stat};
            else if (m_a < 252) m_q = m_seen[(m_a-249)*8 +: 8];
            else m_q = m_out[m_a-252];
            for (int k = 0; k < 3; k++)
                m_chg[k] = m_seen[k*8 +: 8] != m_prev[k*8 +: 8];
            m_clr = (MW && m_a == 248) ? DATA[2:0] : 3'b000;
            m_stat = (m_stat & ~m_clr) | m_chg;
            if (MW && m_a < 248) begin
                m_mem[m_a] = DATA;
                m_known[m_a] = 1'b1;
            end else if (MW && m_a >= 252) m_out[m_a-252] = DATA;
            m_pins.push_front(IN_BUS);
            void'(m_pins.pop_back());
        end
    end

    always @(negedge CLK) begin
        if (go) begin
            if (m_qk) check("Q", 32'(Q), 32'(m_q));
            check("OUT_BUS", OUT_BUS, {m_out[3], m_out[2], m_out[1], m_out[0]});
            check("IRQ", 32'(IRQ), 32'(|m_stat));
        end
    end

    task automatic step(input logic [7:0] a, input logic [7:0] d, input logic w);
        ADDR = a;
        DATA = d;
        MW = w;
        @(posedge CLK);
        #2;
    endtask

    logic [7:0] t_a [7] = '{8'd0, 8'd1, 8'd100, 8'd247, 8'd252, 8'd255, 8'd254};
    logic [7:0] t_d [7] = '{8'h01, 8'hFE, 8'h5A, 8'hC3, 8'h81, 8'h0F, 8'hF0};

    initial begin
        RESET = 1'b1;
        ADDR = 8'h00;
        DATA = 8'h00;
        MW = 1'b0;
        IN_BUS = 24'h0;
        step(8'd0, 8'h00, 1'b0);
        go = 1'b1;
        step(8'd252, 8'h33, 1'b1);
        check("rst_out", OUT_BUS, 32'h0);
        check("rst_q", 32'(Q), 32'h0);
        check("rst_irq", 32'(IRQ), 32'h0);
        RESET = 1'b0;

        for (int a = 0; a < 256; a++) begin
            step(8'(a), 8'h00, 1'b0);
            if (a >= 248) check("io_rd0", 32'(Q), 32'h0);
        end
`ifdef MMIO_DRAM_BCD_LUT_EN
        step(8'd28, 8'h00, 1'b0); check("lut28", 32'(Q), 32'h25);
        step(8'd29, 8'h00, 1'b0); check("lut29", 32'(Q), 32'h01);
        step(8'd58, 8'h00, 1'b0); check("lut58", 32'(Q), 32'h59);
        step(8'd59, 8'h00, 1'b0); check("lut59", 32'(Q), 32'h02);
`endif

        step(8'd10, 8'hA5, 1'b1);
        step(8'd10, 8'h00, 1'b0); check("ram_rd", 32'(Q), 32'hA5);
        step(8'd10, 8'h3C, 1'b1); check("rd_first", 32'(Q), 32'hA5);
        step(8'd10, 8'h00, 1'b0); check("ram_new", 32'(Q), 32'h3C);

        step(8'd253, 8'h7E, 1'b1); check("out_wr", 32'(OUT_BUS[15:8]), 32'h7E);
        step(8'd253, 8'h00, 1'b0); check("out_rd", 32'(Q), 32'h7E);
        step(8'd250, 8'hFF, 1'b1);
        step(8'd250, 8'h00, 1'b0); check("in_ro", 32'(Q), 32'h0);
        check("in_ro_out", OUT_BUS, 32'h00007E00);

        IN_BUS[15:8] = 8'h42;
        step(8'd0, 8'h00, 1'b0);
        step(8'd0, 8'h00, 1'b0); check("irq_early", 32'(IRQ), 32'h0);
        step(8'd250, 8'h00, 1'b0); check("in_rd", 32'(Q), 32'h42);
        check("irq_set", 32'(IRQ), 32'h1);
        step(8'd248, 8'h00, 1'b0); check("stat_rd", 32'(Q), 32'h02);
        step(8'd248, 8'h02, 1'b1); check("w1c_old", 32'(Q), 32'h02);
        check("irq_clr", 32'(IRQ), 32'h0);
        step(8'd248, 8'h00, 1'b0); check("stat_clr", 32'(Q), 32'h0);

        IN_BUS[7:0] = 8'h11;
        step(8'd0, 8'h00, 1'b0);
        step(8'd0, 8'h00, 1'b0);
        step(8'd248, 8'h01, 1'b1); check("set_wins_irq", 32'(IRQ), 32'h1);
        step(8'd248, 8'h00, 1'b0); check("set_wins", 32'(Q), 32'h01);
        step(8'd248, 8'h01, 1'b1); check("clr0", 32'(IRQ), 32'h0);

        for (int i = 0; i < 7; i++) step(t_a[i], t_d[i], 1'b1);
        for (int i = 0; i < 7; i++) begin
            step(t_a[i], 8'h00, 1'b0);
            check("tbl_rd", 32'(Q), 32'(t_d[i]));
        end

        IN_BUS[23:16] = 8'h9C;
        step(8'd0, 8'h00, 1'b0);
        step(8'd0, 8'h00, 1'b0);
        step(8'd251, 8'h00, 1'b0); check("in2_rd", 32'(Q), 32'h9C);
        step(8'd248, 8'h00, 1'b0); check("stat2", 32'(Q), 32'h04);

        IN_BUS = 24'h0;
        step(8'd252, 8'h99, 1'b1); check("pre_rst", 32'(OUT_BUS[7:0]), 32'h99);
        RESET = 1'b1;
        step(8'd252, 8'h55, 1'b1);
        check("mid_rst_out", OUT_BUS, 32'h0);
        check("mid_rst_irq", 32'(IRQ), 32'h0);
        RESET = 1'b0;
        step(8'd252, 8'h00, 1'b0); check("post_rst_q", 32'(Q), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(8'd248, 8'h00, 1'b0);
            check("post_rst_irq", 32'(IRQ), 32'h0);
        end

        go = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
